// File: rtl/vga_scan_driver_if.sv
// vga_scan_driver_if: pixel strobe, offset handshake, sprite ROM bus and video outputs of the scan driver
interface vga_scan_driver_if;
    logic               pix_en;
    logic signed [10:0] offset_row_in;
    logic signed [10:0] offset_col_in;
    logic               offset_valid;
    logic               offset_ready;
    logic signed [10:0] row;
    logic signed [10:0] column;
    logic signed [10:0] row_offset;
    logic signed [10:0] column_offset;
    logic [11:0]        rom_q;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               hsync;
    logic               vsync;
    logic               frame_start;
    modport master (
        input  pix_en, offset_row_in, offset_col_in, offset_valid, rom_q,
        output offset_ready, row, column, row_offset, column_offset,
        output red, green, blue, hsync, vsync, frame_start
    );
    modport slave (
        output pix_en, offset_row_in, offset_col_in, offset_valid, rom_q,
        input  offset_ready, row, column, row_offset, column_offset,
        input  red, green, blue, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: scan timing counters, sprite ROM addressing and registered blanked RGB with aligned syncs
module vga_scan_driver #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input logic               clk,
    input logic               rst,
    vga_scan_driver_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt, v_cnt, row_off, col_off, pend_row, pend_col;
    logic        pending_full, h_last, wrap, xfer;

    assign h_last            = h_cnt == H_LAST;
    assign wrap              = bus.pix_en && h_last && v_cnt == V_LAST;
    assign xfer              = bus.offset_valid && !pending_full;
    assign bus.offset_ready  = ~pending_full;
    assign bus.frame_start   = wrap && !rst;
    assign bus.row           = v_cnt;
    assign bus.column        = h_cnt;
    assign bus.row_offset    = row_off;
    assign bus.column_offset = col_off;

    // scan position: column wraps every line, row advances on each column wrap
    always_ff @(posedge clk)
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 11'd1;
            if (h_last)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end

    // output stage: colour and syncs from the pre-increment position so they stay aligned
    always_ff @(posedge clk)
        if (rst) begin
            {bus.red, bus.green, bus.blue} <= '0;
            bus.hsync <= ~SYNC_ACTIVE;
            bus.vsync <= ~SYNC_ACTIVE;
        end else if (bus.pix_en) begin
            {bus.red, bus.green, bus.blue} <= (h_cnt < H_VIS && v_cnt < V_VIS) ? bus.rom_q : 12'h000;
            bus.hsync <= (h_cnt >= H_SYNC_LO && h_cnt < H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            bus.vsync <= (v_cnt >= V_SYNC_LO && v_cnt < V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end

    // offset handshake: one pending slot, committed only on the frame wrap so frames never tear
    always_ff @(posedge clk)
        if (rst) begin
            row_off      <= '0;
            col_off      <= '0;
            pend_row     <= '0;
            pend_col     <= '0;
            pending_full <= 1'b0;
        end else if (wrap && pending_full) begin
            row_off      <= pend_row;
            col_off      <= pend_col;
            pending_full <= 1'b0;
        end else if (wrap && xfer) begin
            row_off <= bus.offset_row_in;
            col_off <= bus.offset_col_in;
        end else if (xfer) begin
            pend_row     <= bus.offset_row_in;
            pend_col     <= bus.offset_col_in;
            pending_full <= 1'b1;
        end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: directed checks of scan timing, blanking, syncs and frame-aligned offset updates
module tb_vga_scan_driver;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_scan_driver_if b ();
    vga_scan_driver_if b0 ();

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
    ) dut (.clk(clk), .rst(rst), .bus(b));

    vga_scan_driver dut0 (.clk(clk), .rst(rst), .bus(b0));

    assign b.rom_q = {b.row[3:0], b.column[3:0], 4'h5};

    int          n_chk = 0, n_fail = 0;
    int          eh = 0, ev = 0;
    logic [11:0] e_rgb = 12'h000;
    logic        e_hs = 1'b1, e_vs = 1'b1, last_fs = 1'b0;
    int          fs_first = -1, fs_second = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic tick();
        logic e_fs;
        #1;
        e_fs = b.pix_en && !rst && eh == HT - 1 && ev == VT - 1;
        chk("frame_start", 32'(b.frame_start), 32'(e_fs));
        last_fs = b.frame_start;
        if (b.pix_en) begin
            e_rgb = (eh < HA && ev < VA) ? {ev[3:0], eh[3:0], 4'h5} : 12'h000;
            e_hs  = (eh >= HA + HF && eh < HA + HF + HS) ? 1'b0 : 1'b1;
            e_vs  = (ev >= VA + VF && ev < VA + VF + VS) ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            eh = 0; ev = 0; e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
        end else if (b.pix_en) begin
            if (eh == HT - 1) begin
                eh = 0;
                ev = (ev == VT - 1) ? 0 : ev + 1;
            end else eh++;
        end
    endtask

    task automatic chk_out();
        chk("row", 32'(b.row), ev);
        chk("column", 32'(b.column), eh);
        chk("rgb", 32'({b.red, b.green, b.blue}), 32'(e_rgb));
        chk("hsync", 32'(b.hsync), 32'(e_hs));
        chk("vsync", 32'(b.vsync), 32'(e_vs));
    endtask

    task automatic run_to(input int h, input int v);
        b.pix_en = 1'b1;
        for (int n = 0; n < 1000 && !(eh == h && ev == v); n++) begin
            tick();
            chk_out();
        end
    endtask

    initial begin
        rst = 1'b1;
        b.pix_en = 1'b0; b.offset_valid = 1'b0; b.offset_row_in = '0; b.offset_col_in = '0;
        b0.pix_en = 1'b1; b0.offset_valid = 1'b0; b0.offset_row_in = '0; b0.offset_col_in = '0;
        b0.rom_q = 12'hF00;
        tick();
        rst = 1'b0;
        chk("rst_row", 32'(b.row), 0);
        chk("rst_column", 32'(b.column), 0);
        chk("rst_rgb", 32'({b.red, b.green, b.blue}), 0);
        chk("rst_hsync", 32'(b.hsync), 1);
        chk("rst_vsync", 32'(b.vsync), 1);
        chk("rst_ready", 32'(b.offset_ready), 1);
        chk("rst_frame_start", 32'(b.frame_start), 0);
        chk("rst_row_offset", 32'(b.row_offset), 0);
        chk("rst_col_offset", 32'(b.column_offset), 0);
        chk("d0_rst_column", 32'(b0.column), 0);
        // full-size instance: one line with the real 640x480 timing, small instance held
        for (int k = 0; k < 800; k++) begin
            tick();
            chk("d0_rgb", 32'({b0.red, b0.green, b0.blue}), (k < 640) ? 32'hF00 : 32'h0);
            chk("d0_hsync", 32'(b0.hsync), (k >= 656 && k < 752) ? 32'd0 : 32'd1);
        end
        chk("d0_row", 32'(b0.row), 1);
        chk("d0_column", 32'(b0.column), 0);
        chk("d0_vsync", 32'(b0.vsync), 1);
        chk("hold_column", 32'(b.column), 0);
        chk_out();
        // first strobed pixel
        b.pix_en = 1'b1;
        tick();
        chk("first_column", 32'(b.column), 1);
        chk("first_row", 32'(b.row), 0);
        chk("first_rgb", 32'({b.red, b.green, b.blue}), 32'h005);
        chk("first_hsync", 32'(b.hsync), 1);
        chk("first_ready", 32'(b.offset_ready), 1);
        // blanking and sync edges
        run_to(8, 0);  chk("rgb_last_active", 32'({b.red, b.green, b.blue}), 32'h075);
        run_to(9, 0);  chk("rgb_blank", 32'({b.red, b.green, b.blue}), 32'h000);
        run_to(10, 0); chk("hsync_before", 32'(b.hsync), 1);
        run_to(11, 0); chk("hsync_first", 32'(b.hsync), 0);
        run_to(13, 0); chk("hsync_last", 32'(b.hsync), 0);
        run_to(14, 0); chk("hsync_after", 32'(b.hsync), 1);
        run_to(0, 8);  chk("vsync_before", 32'(b.vsync), 1);
        run_to(0, 9);  chk("vsync_first", 32'(b.vsync), 0);
        run_to(0, 10); chk("vsync_last", 32'(b.vsync), 0);
        run_to(1, 10); chk("vsync_after", 32'(b.vsync), 1);
        run_to(14, 11);
        tick();
        chk_out();
        // mid-frame offset request waits for the frame wrap; second request is stalled
        run_to(2, 3);
        b.offset_valid = 1'b1; b.offset_row_in = -11'sd50; b.offset_col_in = 11'sd50;
        chk("ready_idle", 32'(b.offset_ready), 1);
        tick();
        chk("ready_pending", 32'(b.offset_ready), 0);
        chk("row_off_held", 32'(b.row_offset), 0);
        b.offset_row_in = 11'sd7; b.offset_col_in = 11'sd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ready_stall", 32'(b.offset_ready), 0);
        end
        b.offset_valid = 1'b0;
        run_to(14, 11);
        chk("row_off_pre_wrap", 32'(b.row_offset), 0);
        tick();
        chk("row_off_applied", 32'(b.row_offset), -50);
        chk("col_off_applied", 32'(b.column_offset), 50);
        chk("ready_after_wrap", 32'(b.offset_ready), 1);
        // request on the wrap clock with nothing pending goes straight through
        run_to(14, 11);
        b.offset_valid = 1'b1; b.offset_row_in = 11'sd3; b.offset_col_in = -11'sd4;
        chk("ready_on_wrap", 32'(b.offset_ready), 1);
        tick();
        b.offset_valid = 1'b0;
        chk("row_off_direct", 32'(b.row_offset), 3);
        chk("col_off_direct", 32'(b.column_offset), -4);
        chk("ready_direct", 32'(b.offset_ready), 1);
        tick();
        chk("ready_direct_next", 32'(b.offset_ready), 1);
        // half-rate strobe doubles the frame period
        run_to(0, 0);
        for (int i = 0; i < 1000 && fs_second < 0; i++) begin
            b.pix_en = (i % 2 == 0);
            tick();
            chk_out();
            if (last_fs) begin
                if (fs_first < 0) fs_first = i;
                else fs_second = i;
            end
        end
        chk("fs_first", fs_first, 358);
        chk("fs_period", fs_second - fs_first, 2 * HT * VT);
        // reset mid-frame drops the pending offset and restarts the scan
        run_to(5, 3);
        b.offset_valid = 1'b1; b.offset_row_in = 11'sd9; b.offset_col_in = 11'sd9;
        tick();
        b.offset_valid = 1'b0;
        chk("ready_before_rst", 32'(b.offset_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out();
        chk("rst2_row", 32'(b.row), 0);
        chk("rst2_column", 32'(b.column), 0);
        chk("rst2_ready", 32'(b.offset_ready), 1);
        chk("rst2_row_off", 32'(b.row_offset), 0);
        chk("rst2_col_off", 32'(b.column_offset), 0);
        chk("rst2_frame_start", 32'(b.frame_start), 0);
        tick();
        chk("restart_column", 32'(b.column), 1);
        chk("restart_row", 32'(b.row), 0);
        run_to(14, 11);
        tick();
        chk("dropped_row_off", 32'(b.row_offset), 0);
        chk("dropped_ready", 32'(b.offset_ready), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
